// File: rtl/hex_display_scan_if.sv
// Bundle between the value source and the 4-digit 7-segment scanner.
// The master side is the data source or bench. The slave side is the scanner.
interface hex_display_scan_if;
    logic [15:0] value;
    logic        value_valid;
    logic        blank_lz;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    modport master (
        output value, value_valid, blank_lz,
        input  anode, seg, dp, frame_done
    );

    modport slave (
        input  value, value_valid, blank_lz,
        output anode, seg, dp, frame_done
    );
endinterface

// File: rtl/hex_display_scan.sv
// Time-multiplexed 4-digit hex display driver for a common-anode display.
// A new value is staged in 'pending'. It reaches the displayed 'shadow' copy
// only at a frame boundary, so one frame never mixes old and new digits.
module hex_display_scan #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             reset,
    hex_display_scan_if.slave bus
);
    // 21 bits covers the largest legal divider (2^20).
    localparam int PW = 21;
    localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] prescaler;
    logic [1:0]    idx;
    logic [15:0]   pending;
    logic [15:0]   shadow;
    logic          pending_flag;
    logic          tick;
    logic          boundary;
    logic [3:0]    nibble;
    logic          blanked;
    logic [6:0]    seg_next;
    logic [3:0]    anode_next;

    assign tick     = (prescaler == LAST);
    assign boundary = tick && (idx == 2'd3);
    assign bus.dp   = 1'b1;

    // Per-digit dwell counter and the digit scan index
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            idx       <= 2'd0;
        end else if (tick) begin
            prescaler <= '0;
            idx       <= idx + 2'd1;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // Stage strobed values; commit them to the shadow copy on frame boundaries
    always_ff @(posedge clk) begin
        if (reset) begin
            pending      <= '0;
            pending_flag <= 1'b0;
            shadow       <= '0;
        end else if (bus.value_valid) begin
            pending <= bus.value;
            if (boundary) begin
                // A strobe on the boundary cycle goes straight to the display.
                shadow       <= bus.value;
                pending_flag <= 1'b0;
            end else begin
                pending_flag <= 1'b1;
            end
        end else if (boundary && pending_flag) begin
            shadow       <= pending;
            pending_flag <= 1'b0;
        end
    end

    // Select the current nibble, apply leading-zero blanking, and decode
    always_comb begin
        nibble     = shadow[{idx, 2'b00} +: 4];
        blanked    = 1'b0;
        seg_next   = 7'h7F;
        anode_next = 4'b1111;
        if (bus.blank_lz) begin
            case (idx)
                2'd1:    blanked = (shadow[15:4]  == 12'h000);
                2'd2:    blanked = (shadow[15:8]  == 8'h00);
                2'd3:    blanked = (shadow[15:12] == 4'h0);
                default: blanked = 1'b0;
            endcase
        end
        if (!blanked) begin
            anode_next[idx] = 1'b0;
            case (nibble)
                4'h0: seg_next = 7'h40;
                4'h1: seg_next = 7'h79;
                4'h2: seg_next = 7'h24;
                4'h3: seg_next = 7'h30;
                4'h4: seg_next = 7'h19;
                4'h5: seg_next = 7'h12;
                4'h6: seg_next = 7'h02;
                4'h7: seg_next = 7'h78;
                4'h8: seg_next = 7'h00;
                4'h9: seg_next = 7'h10;
                4'hA: seg_next = 7'h08;
                4'hB: seg_next = 7'h03;
                4'hC: seg_next = 7'h46;
                4'hD: seg_next = 7'h21;
                4'hE: seg_next = 7'h06;
                default: seg_next = 7'h0E;
            endcase
        end
    end

    // Register the pin outputs; they lag idx/shadow by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.anode      <= 4'b1111;
            bus.seg        <= 7'h7F;
            bus.frame_done <= 1'b0;
        end else begin
            bus.anode      <= anode_next;
            bus.seg        <= seg_next;
            bus.frame_done <= boundary;
        end
    end
endmodule

// File: tb/tb_hex_display_scan.sv
// Bench for hex_display_scan. It drives two instances (REFRESH_DIV=4 and
// REFRESH_DIV=1) with the same inputs. Each instance is compared every cycle
// against a cycle-count based reference model.
module tb_hex_display_scan;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = '0;
    logic        value_valid = 1'b0;
    logic        blank_lz = 1'b0;

    int passed = 0;
    int total  = 0;

    hex_display_scan_if bus4 ();
    hex_display_scan_if bus1 ();

    assign bus4.value       = value;
    assign bus4.value_valid = value_valid;
    assign bus4.blank_lz    = blank_lz;
    assign bus1.value       = value;
    assign bus1.value_valid = value_valid;
    assign bus1.blank_lz    = blank_lz;

    hex_display_scan #(.REFRESH_DIV(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    hex_display_scan #(.REFRESH_DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    always #5 clk = ~clk;

    // Reference model. The lit digit is derived from the cycle count within the frame.
    typedef struct {
        int          cnt;      // cycles since the start of the current frame
        logic [15:0] pend;
        bit          pflag;
        logic [15:0] shadow;
        logic [3:0]  an;
        logic [6:0]  sg;
        logic        fd;
    } model_t;

    logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic model_t step(model_t m, int div, logic rst, logic [15:0] v,
                                    logic vv, logic blz);
        model_t r = m;
        int     digit;
        bit     bnd;
        bit     blank;
        if (rst) begin
            r.cnt = 0; r.pend = '0; r.pflag = 0; r.shadow = '0;
            r.an = 4'hF; r.sg = 7'h7F; r.fd = 1'b0;
            return r;
        end
        digit = (m.cnt / div) % 4;
        bnd   = (m.cnt % (4 * div)) == (4 * div - 1);
        blank = blz && digit > 0 && ((32'(m.shadow) >> (4 * digit)) == 0);
        if (blank) begin
            r.an = 4'hF;
            r.sg = 7'h7F;
        end else begin
            r.an = ~(4'b0001 << digit);
            r.sg = dec_tab[(m.shadow >> (4 * digit)) & 16'hF];
        end
        r.fd = bnd;
        if (vv) begin
            r.pend = v;
            if (bnd) begin r.shadow = v; r.pflag = 0; end
            else r.pflag = 1;
        end else if (bnd && m.pflag) begin
            r.shadow = m.pend;
            r.pflag  = 0;
        end
        r.cnt = (m.cnt + 1) % (4 * div);
        return r;
    endfunction

    model_t m4, m1;

    // Advance both models on every clock edge, in step with the DUTs
    always @(posedge clk) begin
        m4 = step(m4, 4, reset, value, value_valid, blank_lz);
        m1 = step(m1, 1, reset, value, value_valid, blank_lz);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("div4_anode", 16'(bus4.anode), 16'(m4.an));
        chk("div4_seg",   16'(bus4.seg),   16'(m4.sg));
        chk("div4_dp",    16'(bus4.dp),    16'h1);
        chk("div4_fdone", 16'(bus4.frame_done), 16'(m4.fd));
        chk("div1_anode", 16'(bus1.anode), 16'(m1.an));
        chk("div1_seg",   16'(bus1.seg),   16'(m1.sg));
        chk("div1_fdone", 16'(bus1.frame_done), 16'(m1.fd));
    endtask

    // Advance n cycles, checking at each falling edge
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic strobe(input logic [15:0] v);
        value = v; value_valid = 1'b1;
        cyc(1);
        value_valid = 1'b0;
    endtask

    // Wait (bounded) until the DIV=4 model's next edge is at frame position 'target'
    task automatic wait_pos(input int target);
        int guard = 0;
        while (m4.cnt != target && guard < 64) begin
            cyc(1);
            guard++;
        end
        chk("wait_pos_timeout", 16'(m4.cnt), 16'(target));
    endtask

    initial begin
        // Reset held for 3 cycles
        cyc(3);
        chk("rst_anode", 16'(bus4.anode), 16'hF);
        chk("rst_seg",   16'(bus4.seg),   16'h7F);
        reset = 1'b0;
        cyc(1);
        chk("first_anode", 16'(bus4.anode), 16'hE);
        chk("first_seg",   16'(bus4.seg),   16'h40);
        cyc(40);

        // Strobe mid-frame, then let two frames run
        wait_pos(6);
        strobe(16'h12AB);
        cyc(36);

        // Two strobes in one frame: last wins
        wait_pos(2);
        strobe(16'h1111);
        cyc(3);
        strobe(16'hFFFF);
        cyc(30);

        // Strobe on the exact boundary cycle with blanking on
        blank_lz = 1'b1;
        wait_pos(15);
        strobe(16'h00C5);
        cyc(20);
        strobe(16'h0000);
        cyc(36);

        // No blanking with small value
        blank_lz = 1'b0;
        strobe(16'h0005);
        cyc(36);

        // Reset during digit 2 after loading ABCD
        strobe(16'hABCD);
        cyc(20);
        wait_pos(9);
        reset = 1'b1;
        cyc(3);
        chk("midrst_anode", 16'(bus4.anode), 16'hF);
        chk("midrst_seg",   16'(bus4.seg),   16'h7F);
        reset = 1'b0;
        cyc(1);
        chk("postrst_anode", 16'(bus4.anode), 16'hE);
        chk("postrst_seg",   16'(bus4.seg),   16'h40);
        cyc(20);

        // All 16 nibble codes
        strobe(16'h0123); cyc(20);
        strobe(16'h4567); cyc(20);
        strobe(16'h89AB); cyc(20);
        strobe(16'hCDEF); cyc(20);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 7) == 0) begin
                strobe(16'($urandom >> (4 * $urandom_range(0, 4))));
            end else begin
                value = 16'($urandom);  // changes without a strobe are ignored
                cyc(1);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
